// File: rtl/systolic_2x2_dbuf_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared widths, timing constants and types for the 2x2 double-buffered
// systolic matrix-multiply engine.
//   DATA_W    : element width of the A and B operands (unsigned)
//   ACC_W     : accumulator / result width, at least 2*DATA_W+1 so that the
//               two-term dot product can never overflow
//   LATENCY   : edges from the accepting edge to the result-capture edge
//   NUM_STEPS : feed steps per job before the completion step
// ----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DATA_W    = 4;
  localparam int ACC_W     = 9;
  localparam int LATENCY   = 5;
  localparam int NUM_STEPS = 4;
  localparam int STEP_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Indexed [row][col], zero based: m[0][1] is element (1,2).
  typedef logic [1:0][1:0][DATA_W-1:0] mat2x2_t;
  typedef logic [1:0][1:0][ACC_W-1:0]  acc2x2_t;

endpackage

// File: rtl/systolic_2x2_dbuf_if.sv
// ----------------------------------------------------------------------------
// systolic_2x2_dbuf_if
// Job/result bus of the 2x2 systolic engine.
//   a11..a22, b11..b22 : operand matrices, row-major
//   in_valid           : job strobe, operands sampled on a rising edge with 1
//   c11..c22           : result matrix, row-major
//   out_valid          : one-cycle pulse marking a fresh result
// master drives jobs and receives results; slave is the engine side.
// ----------------------------------------------------------------------------
interface systolic_2x2_dbuf_if;
  import systolic_pkg::*;

  logic [DATA_W-1:0] a11, a12, a21, a22;
  logic [DATA_W-1:0] b11, b12, b21, b22;
  logic              in_valid;
  logic [ACC_W-1:0]  c11, c12, c21, c22;
  logic              out_valid;

  modport master (
    output a11, a12, a21, a22,
    output b11, b12, b21, b22,
    output in_valid,
    input  c11, c12, c21, c22,
    input  out_valid
  );

  modport slave (
    input  a11, a12, a21, a22,
    input  b11, b12, b21, b22,
    input  in_valid,
    output c11, c12, c21, c22,
    output out_valid
  );

endinterface

// File: rtl/systolic_2x2_dbuf_pe.sv
// ----------------------------------------------------------------------------
// systolic_pe
// Output-stationary MAC processing element.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : zero the accumulator and the pass-through registers
//   enable_i   : accumulate a_i*b_i and forward the operands
//   a_i / a_o  : operand entering from the left / registered copy to the right
//   b_i / b_o  : operand entering from the top  / registered copy downward
//   acc_o      : running dot-product
// ----------------------------------------------------------------------------
module systolic_pe
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [DATA_W-1:0] a_q, b_q;
  logic [ACC_W-1:0]  acc_q, acc_d;

  // Full-precision product widened before the add so nothing is truncated.
  always_comb begin
    acc_d = acc_q + (ACC_W'(a_i) * ACC_W'(b_i));
  end

  // Clearing the pass-through registers as well as the accumulator means a
  // new job never multiplies against operands left over from the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clear_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (enable_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_2x2_dbuf.sv
// ----------------------------------------------------------------------------
// systolic_2x2_dbuf
// 2x2 unsigned matrix multiply C = A x B on a 2x2 output-stationary systolic
// array, with a one-deep pending slot so a second job can be queued while the
// first computes and then start with no bubble.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : job/result bus (slave side), see systolic_2x2_dbuf_if
// A job accepted at edge E is fed on E+1..E+4; results are captured at E+5
// and out_valid is high for the cycle after E+5.
// ----------------------------------------------------------------------------
module systolic_2x2_dbuf
  import systolic_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  systolic_2x2_dbuf_if.slave bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  mat2x2_t           actA_q, actA_d, actB_q, actB_d;
  mat2x2_t           pendA_q, pendA_d, pendB_q, pendB_d;
  logic              pendFull_q, pendFull_d;
  acc2x2_t           c_q, c_d;
  logic              outValid_q, outValid_d;

  mat2x2_t           inA, inB;
  acc2x2_t           accs;
  logic              startJob;
  logic              run;
  logic [1:0][DATA_W-1:0] rowFeed, colFeed;

  logic [DATA_W-1:0] aPass11, aPass21, bPass11, bPass12;
  logic [DATA_W-1:0] aOut12_unused, aOut22_unused;
  logic [DATA_W-1:0] bOut21_unused, bOut22_unused;

  assign inA[0][0] = bus.a11;
  assign inA[0][1] = bus.a12;
  assign inA[1][0] = bus.a21;
  assign inA[1][1] = bus.a22;
  assign inB[0][0] = bus.b11;
  assign inB[0][1] = bus.b12;
  assign inB[1][0] = bus.b21;
  assign inB[1][1] = bus.b22;

  assign run = (state_q == RUN);

  // Control: job acceptance, pending-slot handling and result capture.
  // At the completion step a queued job takes precedence over a new strobe,
  // and the strobe then refills the pending slot; outside the completion step
  // a strobe can only go to an empty pending slot and is dropped otherwise.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    actA_d     = actA_q;
    actB_d     = actB_q;
    pendA_d    = pendA_q;
    pendB_d    = pendB_q;
    pendFull_d = pendFull_q;
    c_d        = c_q;
    outValid_d = 1'b0;
    startJob   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          startJob = 1'b1;
          actA_d   = inA;
          actB_d   = inB;
        end
      end
      RUN: begin
        if (step_q == LAST_STEP) begin
          c_d        = accs;
          outValid_d = 1'b1;
          if (pendFull_q) begin
            startJob   = 1'b1;
            actA_d     = pendA_q;
            actB_d     = pendB_q;
            pendFull_d = bus.in_valid;
            if (bus.in_valid) begin
              pendA_d = inA;
              pendB_d = inB;
            end
          end else if (bus.in_valid) begin
            startJob = 1'b1;
            actA_d   = inA;
            actB_d   = inB;
          end else begin
            state_d = IDLE;
          end
        end else begin
          step_d = step_q + 1'b1;
          if (bus.in_valid && !pendFull_q) begin
            pendFull_d = 1'b1;
            pendA_d    = inA;
            pendB_d    = inB;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (startJob) begin
      state_d = RUN;
      step_d  = '0;
    end
  end

  // Skewed edge feeds: row 2 and column 2 lag by one step so each operand
  // pair meets its partner in the right PE; zeros fill every other slot.
  always_comb begin
    rowFeed = '0;
    colFeed = '0;
    if (run) begin
      case (step_q)
        3'd0: begin
          rowFeed[0] = actA_q[0][0];
          colFeed[0] = actB_q[0][0];
        end
        3'd1: begin
          rowFeed[0] = actA_q[0][1];
          rowFeed[1] = actA_q[1][0];
          colFeed[0] = actB_q[1][0];
          colFeed[1] = actB_q[0][1];
        end
        3'd2: begin
          rowFeed[1] = actA_q[1][1];
          colFeed[1] = actB_q[1][1];
        end
        default: begin
          rowFeed = '0;
          colFeed = '0;
        end
      endcase
    end
  end

  // State, operand banks and the output holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      actA_q     <= '0;
      actB_q     <= '0;
      pendA_q    <= '0;
      pendB_q    <= '0;
      pendFull_q <= 1'b0;
      c_q        <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      actA_q     <= actA_d;
      actB_q     <= actB_d;
      pendA_q    <= pendA_d;
      pendB_q    <= pendB_d;
      pendFull_q <= pendFull_d;
      c_q        <= c_d;
      outValid_q <= outValid_d;
    end
  end

  // The right-hand and bottom edge PEs have nowhere to forward operands to.
  systolic_pe pe11 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (startJob),
    .enable_i (run),
    .a_i      (rowFeed[0]),
    .b_i      (colFeed[0]),
    .a_o      (aPass11),
    .b_o      (bPass11),
    .acc_o    (accs[0][0])
  );

  systolic_pe pe12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (startJob),
    .enable_i (run),
    .a_i      (aPass11),
    .b_i      (colFeed[1]),
    .a_o      (aOut12_unused),
    .b_o      (bPass12),
    .acc_o    (accs[0][1])
  );

  systolic_pe pe21 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (startJob),
    .enable_i (run),
    .a_i      (rowFeed[1]),
    .b_i      (bPass11),
    .a_o      (aPass21),
    .b_o      (bOut21_unused),
    .acc_o    (accs[1][0])
  );

  systolic_pe pe22 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (startJob),
    .enable_i (run),
    .a_i      (aPass21),
    .b_i      (bPass12),
    .a_o      (aOut22_unused),
    .b_o      (bOut22_unused),
    .acc_o    (accs[1][1])
  );

  assign bus.c11       = c_q[0][0];
  assign bus.c12       = c_q[0][1];
  assign bus.c21       = c_q[1][0];
  assign bus.c22       = c_q[1][1];
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_systolic_2x2_dbuf.sv
// ----------------------------------------------------------------------------
// tb_systolic_2x2_dbuf
// Scoreboard bench for systolic_2x2_dbuf. A job-level model decides, for each
// strobe, whether the job starts now, waits in the pending slot, or is
// dropped, and queues the expected matrix product with its output edge. A
// separate monitor compares every cycle against the head of that queue.
// ----------------------------------------------------------------------------
module tb_systolic_2x2_dbuf;
  import systolic_pkg::*;

  typedef struct {
    int c11;
    int c12;
    int c21;
    int c22;
    int outEdge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  systolic_2x2_dbuf_if bus ();

  systolic_2x2_dbuf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   checks  = 0;
  int   errors  = 0;
  int   edgeNum = 0;
  bit   mBusy   = 1'b0;
  bit   mPend   = 1'b0;
  int   mEnd    = 0;
  int   lastC[4];

  // Compare one observed value with its expected value.
  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNum, actual, expected);
    end
  endtask

  function automatic mat2x2_t mk(int m11, int m12, int m21, int m22);
    mat2x2_t m;
    m[0][0] = DATA_W'(m11);
    m[0][1] = DATA_W'(m12);
    m[1][0] = DATA_W'(m21);
    m[1][1] = DATA_W'(m22);
    return m;
  endfunction

  function automatic mat2x2_t randMat();
    return mk($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
  endfunction

  // Plain 2x2 matrix product, tagged with the edge the result is due on.
  function automatic exp_t matMul(mat2x2_t a, mat2x2_t b, int outEdge);
    exp_t e;
    e.c11 = int'(a[0][0]) * int'(b[0][0]) + int'(a[0][1]) * int'(b[1][0]);
    e.c12 = int'(a[0][0]) * int'(b[0][1]) + int'(a[0][1]) * int'(b[1][1]);
    e.c21 = int'(a[1][0]) * int'(b[0][0]) + int'(a[1][1]) * int'(b[1][0]);
    e.c22 = int'(a[1][0]) * int'(b[0][1]) + int'(a[1][1]) * int'(b[1][1]);
    e.outEdge = outEdge;
    return e;
  endfunction

  // Job-level model: one job in flight finishing LATENCY edges after it
  // starts, plus at most one waiting job that starts when the active one ends.
  task automatic modelStep(bit valid, mat2x2_t a, mat2x2_t b);
    if (mBusy && edgeNum == mEnd) begin
      if (mPend) begin
        mEnd  = mEnd + LATENCY;
        mPend = 1'b0;
      end else begin
        mBusy = 1'b0;
      end
    end
    if (valid) begin
      if (!mBusy) begin
        mBusy = 1'b1;
        mEnd  = edgeNum + LATENCY;
        expQ.push_back(matMul(a, b, mEnd));
      end else if (!mPend) begin
        mPend = 1'b1;
        expQ.push_back(matMul(a, b, mEnd + LATENCY));
      end else begin
        $display("[TB] job at edge %0d dropped, pending slot occupied", edgeNum);
      end
    end
  endtask

  // Drive one clock of stimulus; the DUT samples it on the next rising edge.
  task automatic applyStimulus(bit valid, mat2x2_t a, mat2x2_t b);
    bus.in_valid = valid;
    bus.a11 = a[0][0];
    bus.a12 = a[0][1];
    bus.a21 = a[1][0];
    bus.a22 = a[1][1];
    bus.b11 = b[0][0];
    bus.b12 = b[0][1];
    bus.b21 = b[1][0];
    bus.b22 = b[1][1];
    @(posedge clk);
    edgeNum++;
    if (rst_n) modelStep(valid, a, b);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
  endtask

  task automatic enterReset();
    rst_n = 1'b0;
    expQ.delete();
    mBusy = 1'b0;
    mPend = 1'b0;
    lastC = '{0, 0, 0, 0};
  endtask

  function automatic logic [63:0] packC();
    return 64'({bus.c11, bus.c12, bus.c21, bus.c22});
  endfunction

  function automatic logic [63:0] packLast();
    return 64'({ACC_W'(lastC[0]), ACC_W'(lastC[1]), ACC_W'(lastC[2]), ACC_W'(lastC[3])});
  endfunction

  // Monitor: checks every cycle, away from the rising edge.
  initial begin
    exp_t e;
    bit   expValid;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_c", packC(), 64'd0);
      end else begin
        expValid = (expQ.size() > 0) && (expQ[0].outEdge == edgeNum);
        if (expValid || bus.out_valid) begin
          checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
          if (expValid) begin
            e = expQ.pop_front();
            checkOutput("c11", 64'(bus.c11), 64'(e.c11));
            checkOutput("c12", 64'(bus.c12), 64'(e.c12));
            checkOutput("c21", 64'(bus.c21), 64'(e.c21));
            checkOutput("c22", 64'(bus.c22), 64'(e.c22));
            lastC = '{e.c11, e.c12, e.c21, e.c22};
          end
        end else begin
          checkOutput("c_hold", packC(), packLast());
        end
      end
    end
  end

  // Directed scenarios followed by a randomized stream.
  initial begin
    bus.in_valid = 1'b0;
    bus.a11 = '0; bus.a12 = '0; bus.a21 = '0; bus.a22 = '0;
    bus.b11 = '0; bus.b12 = '0; bus.b21 = '0; bus.b22 = '0;
    enterReset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single job");
    applyStimulus(1'b1, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    idle(8);

    $display("[TB] overlapped jobs four edges apart");
    applyStimulus(1'b1, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    idle(3);
    applyStimulus(1'b1, mk(1, 1, 1, 1), mk(1, 1, 1, 1));
    idle(11);

    $display("[TB] issue after idle");
    idle(2);
    applyStimulus(1'b1, mk(1, 0, 0, 1), mk(2, 3, 4, 5));
    idle(8);

    $display("[TB] maximum operands");
    applyStimulus(1'b1, mk(15, 15, 15, 15), mk(15, 15, 15, 15));
    idle(9);

    $display("[TB] three strobes in a row");
    applyStimulus(1'b1, randMat(), randMat());
    applyStimulus(1'b1, randMat(), randMat());
    applyStimulus(1'b1, randMat(), randMat());
    idle(14);

    $display("[TB] strobe on completion edge with pending full");
    applyStimulus(1'b1, randMat(), randMat());
    applyStimulus(1'b1, randMat(), randMat());
    idle(3);
    applyStimulus(1'b1, randMat(), randMat());
    idle(16);

    $display("[TB] reset during a job");
    applyStimulus(1'b1, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    applyStimulus(1'b1, randMat(), randMat());
    idle(2);
    enterReset();
    #1;
    checkOutput("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_reset_c", packC(), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    applyStimulus(1'b1, mk(2, 3, 4, 5), mk(6, 7, 8, 9));
    idle(8);

    $display("[TB] random stream");
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, randMat(), randMat());
    end
    idle(14);

    checkOutput("results_outstanding", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
